// File: rtl/output_accum_pkg.sv
// Shared sizing and packed-bus lane helpers for the RAM_O write-back stage.
// Every lane owns one address slice and one data slice of the packed buses.
package output_accum_pkg;

  localparam int unsigned RAM_O_SIZE     = 256;
  localparam int unsigned ARRAY_M        = 8;
  localparam int unsigned ADDR_WIDTH     = $clog2(RAM_O_SIZE);
  localparam int unsigned ADDR_SET_WIDTH = ADDR_WIDTH * ARRAY_M;
  localparam int unsigned PSUM_WIDTH     = 32;
  localparam int unsigned DATA_SET_WIDTH = PSUM_WIDTH * ARRAY_M;

  function automatic logic [ADDR_WIDTH-1:0] addrSlice(
    input logic [ADDR_SET_WIDTH-1:0] bus,
    input int unsigned               lane
  );
    return bus[lane*ADDR_WIDTH +: ADDR_WIDTH];
  endfunction

  function automatic logic [PSUM_WIDTH-1:0] dataSlice(
    input logic [DATA_SET_WIDTH-1:0] bus,
    input int unsigned               lane
  );
    return bus[lane*PSUM_WIDTH +: PSUM_WIDTH];
  endfunction

endpackage

// File: rtl/output_accum_lane.sv
// One column of the write-back pipeline: S1 capture, read-modify-write adder,
// S2 write register and a trailing W register used only for forwarding.
module output_accum_lane
  import output_accum_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_WIDTH,
  parameter int unsigned DATA_W = PSUM_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_i,
  input  logic              accumulate_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] psum_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              ren_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              we_o,
  output logic              busy_o
);

  logic              s1Valid_q, s1Valid_d;
  logic              s1Acc_q, s1Acc_d;
  logic [ADDR_W-1:0] s1Addr_q, s1Addr_d;
  logic [DATA_W-1:0] s1Psum_q, s1Psum_d;

  logic              s2Valid_q, s2Valid_d;
  logic [ADDR_W-1:0] s2Addr_q, s2Addr_d;
  logic [DATA_W-1:0] s2Data_q, s2Data_d;

  logic              wValid_q, wValid_d;
  logic [ADDR_W-1:0] wAddr_q, wAddr_d;
  logic [DATA_W-1:0] wData_q, wData_d;

  logic [DATA_W-1:0] base;
  logic [DATA_W-1:0] sum;

  // The RAM is read-first, so a word written by the element two ahead is not
  // yet visible in rdata; W covers that gap and S2 covers the element just ahead.
  always_comb begin
    base = rdata_i;
    if (s2Valid_q && (s2Addr_q == s1Addr_q)) begin
      base = s2Data_q;
    end else if (wValid_q && (wAddr_q == s1Addr_q)) begin
      base = wData_q;
    end
    sum = s1Acc_q ? (base + s1Psum_q) : s1Psum_q;

    s1Valid_d = enable_i;
    s1Acc_d   = accumulate_i;
    s1Addr_d  = addr_i;
    s1Psum_d  = psum_i;

    s2Valid_d = s1Valid_q;
    s2Addr_d  = s1Addr_q;
    s2Data_d  = sum;

    wValid_d  = s2Valid_q;
    wAddr_d   = s2Addr_q;
    wData_d   = s2Data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1Valid_q <= 1'b0;
      s1Acc_q   <= 1'b0;
      s1Addr_q  <= '0;
      s1Psum_q  <= '0;
      s2Valid_q <= 1'b0;
      s2Addr_q  <= '0;
      s2Data_q  <= '0;
      wValid_q  <= 1'b0;
      wAddr_q   <= '0;
      wData_q   <= '0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s1Acc_q   <= s1Acc_d;
      s1Addr_q  <= s1Addr_d;
      s1Psum_q  <= s1Psum_d;
      s2Valid_q <= s2Valid_d;
      s2Addr_q  <= s2Addr_d;
      s2Data_q  <= s2Data_d;
      wValid_q  <= wValid_d;
      wAddr_q   <= wAddr_d;
      wData_q   <= wData_d;
    end
  end

  assign ren_o   = enable_i & accumulate_i;
  assign waddr_o = s2Addr_q;
  assign wdata_o = s2Data_q;
  assign we_o    = s2Valid_q;
  assign busy_o  = s1Valid_q | s2Valid_q;

endmodule

// File: rtl/output_accumulator_o.sv
// Write-back stage feeding the RAM_O banks: slices the packed buses into
// independent lanes and derives the run-level busy/done handshake.
module output_accumulator_o
  import output_accum_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      accumulate,
  input  logic [DATA_SET_WIDTH-1:0] psum_set,
  input  logic [ADDR_SET_WIDTH-1:0] addr_set,
  input  logic [ARRAY_M-1:0]        enable_set,
  output logic [ADDR_SET_WIDTH-1:0] ram_raddr_set,
  output logic [ARRAY_M-1:0]        ram_ren_set,
  input  logic [DATA_SET_WIDTH-1:0] ram_rdata_set,
  output logic [ADDR_SET_WIDTH-1:0] ram_waddr_set,
  output logic [DATA_SET_WIDTH-1:0] ram_wdata_set,
  output logic [ARRAY_M-1:0]        ram_we_set,
  output logic                      busy,
  output logic                      done
);

  logic [ARRAY_M-1:0] laneBusy;
  logic               busyPrev_q;
  logic               done_q, done_d;

  for (genvar c = 0; c < ARRAY_M; c++) begin : gLane
    output_accum_lane #(
      .ADDR_W (ADDR_WIDTH),
      .DATA_W (PSUM_WIDTH)
    ) uLane (
      .clk          (clk),
      .reset        (reset),
      .enable_i     (enable_set[c]),
      .accumulate_i (accumulate),
      .addr_i       (addrSlice(addr_set, c)),
      .psum_i       (dataSlice(psum_set, c)),
      .rdata_i      (dataSlice(ram_rdata_set, c)),
      .ren_o        (ram_ren_set[c]),
      .waddr_o      (ram_waddr_set[c*ADDR_WIDTH +: ADDR_WIDTH]),
      .wdata_o      (ram_wdata_set[c*PSUM_WIDTH +: PSUM_WIDTH]),
      .we_o         (ram_we_set[c]),
      .busy_o       (laneBusy[c])
    );
  end

  assign ram_raddr_set = addr_set;

  // done marks the falling edge of busy; a reset clears the history so an
  // aborted run never produces a pulse.
  always_comb begin
    busy   = (|enable_set) | (|laneBusy);
    done_d = busyPrev_q & ~busy;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busyPrev_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      busyPrev_q <= busy;
      done_q     <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_output_accumulator_o.sv
// Directed bench for output_accumulator_o: a banked RAM model answers reads,
// a reference memory predicts every write and a per-lane scoreboard checks them.
module tb_output_accumulator_o;
  import output_accum_pkg::*;

  localparam int NL = ARRAY_M;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [PSUM_WIDTH-1:0] data;
    int                    cyc;
  } wrEntry_t;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      accumulate;
  logic [DATA_SET_WIDTH-1:0] psumSet;
  logic [ADDR_SET_WIDTH-1:0] addrSet;
  logic [NL-1:0]             enableSet;
  logic [ADDR_SET_WIDTH-1:0] ramRaddrSet;
  logic [NL-1:0]             ramRenSet;
  logic [DATA_SET_WIDTH-1:0] ramRdataSet;
  logic [ADDR_SET_WIDTH-1:0] ramWaddrSet;
  logic [DATA_SET_WIDTH-1:0] ramWdataSet;
  logic [NL-1:0]             ramWeSet;
  logic                      busy;
  logic                      done;

  int testCount  = 0;
  int failCount  = 0;
  int doneCount  = 0;
  int writeCount = 0;
  int cycleCnt   = 0;

  logic [PSUM_WIDTH-1:0] ramMem [NL][RAM_O_SIZE];
  logic [PSUM_WIDTH-1:0] refMem [NL][RAM_O_SIZE];
  wrEntry_t              expQ [NL][$];

  logic                  ramClear    = 1'b0;
  logic                  preloadEn   = 1'b0;
  int                    preloadLane = 0;
  addr_t                 preloadAddr = '0;
  logic [PSUM_WIDTH-1:0] preloadData = '0;

  output_accumulator_o dut (
    .clk           (clk),
    .reset         (reset),
    .accumulate    (accumulate),
    .psum_set      (psumSet),
    .addr_set      (addrSet),
    .enable_set    (enableSet),
    .ram_raddr_set (ramRaddrSet),
    .ram_ren_set   (ramRenSet),
    .ram_rdata_set (ramRdataSet),
    .ram_waddr_set (ramWaddrSet),
    .ram_wdata_set (ramWdataSet),
    .ram_we_set    (ramWeSet),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Banked RAM model: one-cycle read latency, read-first on a same-cycle write.
  always @(posedge clk) begin
    for (int c = 0; c < NL; c++) begin
      if (ramRenSet[c])
        ramRdataSet[c*PSUM_WIDTH +: PSUM_WIDTH] <= ramMem[c][ramRaddrSet[c*ADDR_WIDTH +: ADDR_WIDTH]];
      if (ramWeSet[c])
        ramMem[c][ramWaddrSet[c*ADDR_WIDTH +: ADDR_WIDTH]] <= ramWdataSet[c*PSUM_WIDTH +: PSUM_WIDTH];
    end
    if (ramClear)
      for (int c = 0; c < NL; c++)
        for (int a = 0; a < RAM_O_SIZE; a++)
          ramMem[c][a] <= '0;
    if (preloadEn)
      ramMem[preloadLane][preloadAddr] <= preloadData;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Every write the DUT issues must match the oldest prediction for its lane,
  // in content and in the cycle it was due.
  always @(negedge clk) begin
    wrEntry_t e;
    if (done === 1'b1) doneCount++;
    for (int c = 0; c < NL; c++) begin
      if (ramWeSet[c] === 1'b1) begin
        writeCount++;
        if (expQ[c].size() == 0) begin
          checkOutput($sformatf("unexpected we lane%0d", c), 32'(ramWeSet[c]), 32'd0);
        end else begin
          e = expQ[c].pop_front();
          checkOutput($sformatf("waddr lane%0d", c), 32'(ramWaddrSet[c*ADDR_WIDTH +: ADDR_WIDTH]), 32'(e.addr));
          checkOutput($sformatf("wdata lane%0d", c), ramWdataSet[c*PSUM_WIDTH +: PSUM_WIDTH], e.data);
          checkOutput($sformatf("wcycle lane%0d", c), 32'(cycleCnt), 32'(e.cyc));
        end
      end else if (expQ[c].size() != 0 && expQ[c][0].cyc <= cycleCnt) begin
        checkOutput($sformatf("missing we lane%0d", c), 32'(ramWeSet[c]), 32'd1);
        void'(expQ[c].pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitNeg();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clearInputs();
    enableSet  = '0;
    addrSet    = '0;
    psumSet    = '0;
    accumulate = 1'b0;
  endtask

  task automatic preloadWord(input int lane, input addr_t addr, input logic [PSUM_WIDTH-1:0] data);
    preloadEn   = 1'b1;
    preloadLane = lane;
    preloadAddr = addr;
    preloadData = data;
    refMem[lane][addr] = data;
    tick();
    preloadEn = 1'b0;
  endtask

  // Drives one element on a lane using the current accumulate level and
  // predicts the word it must leave in RAM two cycles later.
  task automatic applyStimulus(input int lane, input addr_t addr, input logic [PSUM_WIDTH-1:0] psum);
    logic [PSUM_WIDTH-1:0] expVal;
    enableSet[lane] = 1'b1;
    addrSet[lane*ADDR_WIDTH +: ADDR_WIDTH] = addr;
    psumSet[lane*PSUM_WIDTH +: PSUM_WIDTH] = psum;
    expVal = accumulate ? refMem[lane][addr] + psum : psum;
    refMem[lane][addr] = expVal;
    expQ[lane].push_back('{addr, expVal, cycleCnt + 2});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int doneBefore;
    int writesBefore;
    int budget;

    for (int c = 0; c < NL; c++)
      for (int a = 0; a < RAM_O_SIZE; a++)
        refMem[c][a] = '0;

    clearInputs();
    reset    = 1'b1;
    ramClear = 1'b1;
    tick();
    tick();
    ramClear = 1'b0;
    waitNeg();
    checkOutput("reset we", 32'(ramWeSet), 32'd0);
    checkOutput("reset waddr", 32'(ramWaddrSet[31:0]), 32'd0);
    checkOutput("reset wdata", ramWdataSet[31:0], 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Overwrite: no read, write two cycles later, busy then a single done.
    accumulate = 1'b0;
    applyStimulus(0, addr_t'(16), 32'd5);
    #1;
    checkOutput("s1 ren0", 32'(ramRenSet[0]), 32'd0);
    checkOutput("s1 raddr0", 32'(ramRaddrSet[ADDR_WIDTH-1:0]), 32'd16);
    tick();
    clearInputs();
    waitNeg();
    checkOutput("s1 busy t1", 32'(busy), 32'd1);
    tick();
    waitNeg();
    checkOutput("s1 busy t2", 32'(busy), 32'd1);
    tick();
    waitNeg();
    checkOutput("s1 busy t3", 32'(busy), 32'd0);
    checkOutput("s1 done t3", 32'(done), 32'd0);
    tick();
    waitNeg();
    checkOutput("s1 done t4", 32'(done), 32'd1);
    tick();
    waitNeg();
    checkOutput("s1 done t5", 32'(done), 32'd0);
    idle(3);

    // Accumulate onto a preloaded word.
    preloadWord(0, addr_t'(16), 32'd10);
    accumulate = 1'b1;
    applyStimulus(0, addr_t'(16), 32'd5);
    #1;
    checkOutput("s2 ren0", 32'(ramRenSet[0]), 32'd1);
    tick();
    clearInputs();
    idle(5);

    // Back-to-back same address exercises S2 forwarding.
    preloadWord(0, addr_t'(16), 32'd0);
    accumulate = 1'b1;
    applyStimulus(0, addr_t'(16), 32'd1);
    tick();
    applyStimulus(0, addr_t'(16), 32'd2);
    tick();
    applyStimulus(0, addr_t'(16), 32'd3);
    tick();
    clearInputs();
    idle(5);

    // Same address two apart exercises W forwarding past a read-first RAM.
    preloadWord(1, addr_t'(30), 32'd100);
    accumulate = 1'b1;
    applyStimulus(1, addr_t'(30), 32'd4);
    tick();
    enableSet = '0;
    applyStimulus(1, addr_t'(31), 32'd5);
    tick();
    enableSet = '0;
    applyStimulus(1, addr_t'(30), 32'd6);
    tick();
    clearInputs();
    idle(5);

    // Overwrite followed by accumulate must build on the forwarded value.
    accumulate = 1'b0;
    applyStimulus(4, addr_t'(50), 32'd7);
    tick();
    accumulate = 1'b1;
    applyStimulus(4, addr_t'(50), 32'd3);
    tick();
    clearInputs();
    idle(5);

    // Modulo wrap of the adder.
    preloadWord(2, addr_t'(20), 32'hFFFF_FFFF);
    accumulate = 1'b1;
    applyStimulus(2, addr_t'(20), 32'd2);
    tick();
    clearInputs();
    idle(5);

    // Skewed full-array run, as produced upstream for 8 columns from base 16.
    doneBefore   = doneCount;
    writesBefore = writeCount;
    accumulate   = 1'b1;
    for (int s = 0; s < 15; s++) begin
      enableSet = '0;
      for (int c = 0; c < NL; c++)
        if (s >= c && s < c + 8)
          applyStimulus(c, addr_t'(16 + s - c), 32'(s * 16 + c + 1));
      tick();
    end
    clearInputs();
    for (budget = 0; budget < 20; budget++) begin
      waitNeg();
      if (busy === 1'b0) break;
      tick();
    end
    checkOutput("s5 busy falls", 32'(busy), 32'd0);
    tick();
    waitNeg();
    checkOutput("s5 done pulse", 32'(done), 32'd1);
    tick();
    waitNeg();
    checkOutput("s5 done end", 32'(done), 32'd0);
    checkOutput("s5 done count", 32'(doneCount - doneBefore), 32'd1);
    checkOutput("s5 write count", 32'(writeCount - writesBefore), 32'd64);
    idle(3);

    // Reset with every lane holding elements in S1 and S2.
    accumulate = 1'b0;
    for (int c = 0; c < NL; c++) applyStimulus(c, addr_t'(100 + c), 32'(1000 + c));
    tick();
    for (int c = 0; c < NL; c++) applyStimulus(c, addr_t'(110 + c), 32'(2000 + c));
    tick();
    reset     = 1'b1;
    enableSet = '1;
    addrSet   = '1;
    psumSet   = '1;
    doneBefore = doneCount;
    waitNeg();
    tick();
    reset = 1'b0;
    clearInputs();
    for (int c = 0; c < NL; c++) expQ[c].delete();
    waitNeg();
    checkOutput("s6 we", 32'(ramWeSet), 32'd0);
    checkOutput("s6 busy", 32'(busy), 32'd0);
    checkOutput("s6 waddr", 32'(ramWaddrSet[31:0]), 32'd0);
    checkOutput("s6 wdata", ramWdataSet[31:0], 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      waitNeg();
      checkOutput("s6 no done", 32'(done), 32'd0);
    end
    checkOutput("s6 done count", 32'(doneCount - doneBefore), 32'd0);
    tick();

    accumulate = 1'b0;
    applyStimulus(3, addr_t'(16), 32'd5);
    #1;
    checkOutput("s6 ren3", 32'(ramRenSet[3]), 32'd0);
    tick();
    clearInputs();
    idle(5);

    for (int c = 0; c < NL; c++)
      checkOutput($sformatf("drain lane%0d", c), 32'(expQ[c].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
